// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, bit-serial shifts
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_controls,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             srl_q, srl_d;
  logic [SW-1:0]    shamt;

  assign shamt = src_b[SW-1:0];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    srl_d    = srl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DONE;
          case (alu_controls)
            3'b000: result_d = src_a + src_b;
            3'b001: result_d = src_a - src_b;
            3'b010: result_d = src_a & src_b;
            3'b011: result_d = src_a | src_b;
            3'b100: result_d = src_a ^ src_b;
            3'b101: result_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: begin
              // Shifts run serially in the result register; a zero shift skips SHIFT.
              result_d = src_a;
              srl_d    = alu_controls[0];
              if (shamt != '0) begin
                cnt_d   = shamt;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        result_d = srl_q ? {1'b0, result_q[WIDTH-1:1]} : {result_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
      srl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      srl_q    <= srl_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign alu_result = result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  alu_controls;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] alu_result;
  logic        zero;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_controls(alu_controls),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .alu_result(alu_result), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    if (op >= 3'd6) return 1 + int'(b % 32);
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally spamming start with junk operands while busy.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit pulse);
    logic [31:0] exp_r;
    int          exp_l;
    int          cycles;
    bit          seen;
    exp_r = ref_result(op, a, b);
    exp_l = ref_latency(op, b);
    @(negedge clk);
    start = 1'b1; alu_controls = op; src_a = a; src_b = b;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      seen = done;
      if (!seen && busy !== 1'b1) cycles = 40;
      start        = pulse;
      alu_controls = 3'($urandom);
      src_a        = $urandom;
      src_b        = $urandom;
    end
    chk({tag, ".lat"},  32'(cycles), 32'(exp_l));
    chk({tag, ".res"},  alu_result, exp_r);
    chk({tag, ".zero"}, 32'(zero), 32'(exp_r == 32'd0));
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, ".hold"}, alu_result, exp_r);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_controls = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst.flags", {29'd0, busy, done, zero}, 32'd1);
    chk("rst.res", alu_result, 32'd0);
    reset = 1'b0;

    run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op("sub_neg",  3'd1, 32'd5, 32'd7, 1'b0);
    run_op("slt_neg",  3'd5, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_op("sll_max",  3'd6, 32'h1, 32'h1F, 1'b0);
    run_op("srl_4",    3'd7, 32'h8000_0000, 32'h4, 1'b0);
    run_op("srl_0",    3'd7, 32'h1234_5678, 32'h20, 1'b0);
    run_op("sll_ign",  3'd6, 32'hA5A5_0001, 32'h3, 1'b1);
    run_op("and_ign",  3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    run_op("after_ign", 3'd3, 32'h0, 32'h0, 1'b0);

    // Reset in the middle of a 10-bit shift, with start held high during reset.
    @(negedge clk);
    start = 1'b1; alu_controls = 3'd6; src_a = 32'h3; src_b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid.flags", {29'd0, busy, done, zero}, 32'd1);
    chk("rst_mid.res", alu_result, 32'd0);
    @(negedge clk);
    chk("rst_mid.start_ign", {30'd0, busy, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_mid.no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op("post_rst", 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 5 == 0) a = b;
      run_op("rand", op, a, b, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width; shift amount is src_b[$clog2(WIDTH)-1:0] (5 bits at default).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: alu_controls  input  3  operation code from the ALU decoder.
REQ-006 SHALL have port: src_a  input  WIDTH  first operand.
REQ-007 SHALL have port: src_b  input  WIDTH  second operand / shift amount source.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; alu_result valid from this cycle.
REQ-010 SHALL have port: alu_result  output  WIDTH  registered result.
REQ-011 SHALL have port: zero  output  1  registered flag, high when alu_result == 0.

Function
REQ-012 SHALL decode alu_controls: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl (logical).
REQ-013 SHALL implement states IDLE, SHIFT, DONE, with busy = (state != IDLE) and done = (state == DONE).
REQ-014 SHALL accept an operation when state == IDLE and start == 1 at a clock edge (cycle T), latching alu_controls, src_a, and src_b.
REQ-015 For non-shift ops, SHALL register the result at the accepting edge and enter DONE; done is high in cycle T+1 (latency 1).
REQ-016 For add/sub, SHALL wrap modulo 2^WIDTH; carry and overflow are discarded.
REQ-017 For slt, SHALL produce result 1 if signed src_a < signed src_b, else 0, zero-extended to WIDTH.
REQ-018 For sll/srl with shamt == 0, SHALL load alu_result = src_a and enter DONE directly; latency 1.
REQ-019 For sll/srl with shamt > 0, SHALL load the accumulator = src_a and the counter = shamt, then enter SHIFT.
REQ-020 In SHIFT, SHALL shift the accumulator one bit per cycle (sll inserts 0 at the LSB, srl inserts 0 at the MSB) and decrement the counter.
REQ-021 SHALL leave SHIFT for DONE on the edge that performs the final shift (counter == 1); done is high in cycle T+1+shamt.
REQ-022 alu_result SHALL show the accumulator during SHIFT; the value is only guaranteed correct when done is high.
REQ-023 SHALL hold alu_result and zero stable from DONE until the next accepted operation.
REQ-024 SHALL transition DONE -> IDLE unconditionally after one cycle; start in a DONE or SHIFT cycle SHALL be ignored with no queuing.
REQ-025 Input changes on alu_controls, src_a, or src_b while busy SHALL NOT affect the operation in progress.
REQ-026 A maximum shift of 31 SHALL take 31 SHIFT cycles; done is high in cycle T+32.

Reset
REQ-027 When reset is high at an edge, SHALL enter IDLE and set busy = 0, done = 0, alu_result = 0, zero = 1, and counter = 0, overriding any other input.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; start is ignored while reset is high.
REQ-029 After reset deasserts, the first start SHALL be accepted in the next IDLE cycle.

Verification
REQ-030 SHALL verify: add 0xFFFFFFFF + 0x00000001 -> done at T+1, alu_result = 0x00000000, zero = 1.
REQ-031 SHALL verify: sub 5 - 7 -> alu_result = 0xFFFFFFFE at T+1; slt 0xFFFFFFFE vs 0x00000001 -> alu_result = 1.
REQ-032 SHALL verify: sll 0x00000001 by src_b = 0x0000001F -> busy for 32 cycles, done at T+32, alu_result = 0x80000000.
REQ-033 SHALL verify: srl 0x80000000 by src_b = 0x00000004 -> done at T+5, alu_result = 0x08000000; srl by 0 -> done at T+1, alu_result = src_a.
REQ-034 SHALL verify: start re-pulsed with new operands during SHIFT and DONE -> ignored; original result unchanged; next start in IDLE is accepted.
REQ-035 SHALL verify: reset asserted at cycle T+3 of a 10-bit shift -> IDLE next cycle, alu_result = 0, zero = 1, no done pulse.
